// File: rtl/alarm_timer.sv
// alarm_timer: seconds countdown timer for the alarm sequencer.
//   Four 4-bit duration registers (arm, driver, passenger, alarm-on) can be
//   reprogrammed at run time. A start request loads the selected duration
//   and counts it down once per one-second tick. A one-cycle expired pulse
//   marks the end of the countdown.
//
// Ports:
//   i_clk            system clock, all state changes on its rising edge
//   i_reset          synchronous active-high reset
//   i_start_timer    one-cycle request to load and start (or restart) the countdown
//   i_interval       duration select: 00 arm, 01 driver, 10 passenger, 11 alarm-on
//   i_reprogram      one-cycle strobe writing i_time_value into the selected register
//   i_time_param_sel register to reprogram, same encoding as i_interval
//   i_time_value     new duration in seconds (0-15)
//   o_expired        one-cycle pulse when the countdown reaches zero
//   o_one_hz         one-cycle tick, only while counting
//   o_remaining      seconds left in the current countdown
//   o_busy           high while counting
//
// Build option: define ALARM_TIMER_FASTSIM_EN to shorten the one-second
// tick to 8 clocks for simulation; otherwise a tick is CLK_HZ clocks.
//
// State table:
//   S_IDLE | divider held at 0, remaining holds its value
//   S_RUN  | divider counting, remaining decremented once per tick

module alarm_timer #(
  parameter int CLK_HZ      = 27000000,
  parameter int T_ARM       = 6,
  parameter int T_DRIVER    = 8,
  parameter int T_PASSENGER = 15,
  parameter int T_ALARM     = 10
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start_timer,
  input  logic [1:0] i_interval,
  input  logic       i_reprogram,
  input  logic [1:0] i_time_param_sel,
  input  logic [3:0] i_time_value,
  output logic       o_expired,
  output logic       o_one_hz,
  output logic [3:0] o_remaining,
  output logic       o_busy
);

`ifdef ALARM_TIMER_FASTSIM_EN
  localparam int N_DIV = 8;
`else
  localparam int N_DIV = CLK_HZ;
`endif
  localparam int DIV_W = (N_DIV > 1) ? $clog2(N_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(N_DIV - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic [3:0]       r_remaining;
  logic [3:0]       w_remaining_nxt;
  logic             r_expired;
  logic             w_expired_nxt;
  logic [3:0]       r_dur [4];
  logic             w_tick;
  logic [3:0]       w_load_val;

  assign w_tick     = (r_state == S_RUN) && (r_div == DIV_LAST);
  // Read before any same-edge reprogram lands, so a simultaneous start
  // loads the previous duration.
  assign w_load_val = r_dur[i_interval];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_remaining <= '0;
      r_expired   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_div       <= w_div_nxt;
      r_remaining <= w_remaining_nxt;
      r_expired   <= w_expired_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dur[0] <= 4'(T_ARM);
      r_dur[1] <= 4'(T_DRIVER);
      r_dur[2] <= 4'(T_PASSENGER);
      r_dur[3] <= 4'(T_ALARM);
    end else if (i_reprogram) begin
      r_dur[i_time_param_sel] <= i_time_value;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_div_nxt       = r_div;
    w_remaining_nxt = r_remaining;
    w_expired_nxt   = 1'b0;

    if (i_start_timer) begin
      // Start overrides any tick in the same cycle.
      w_div_nxt       = '0;
      w_remaining_nxt = w_load_val;
      if (w_load_val == 4'd0) begin
        // Nothing to count: report expiry immediately, never enter RUN.
        w_state_nxt   = S_IDLE;
        w_expired_nxt = 1'b1;
      end else begin
        w_state_nxt   = S_RUN;
      end
    end else if (r_state == S_RUN) begin
      if (w_tick) begin
        w_div_nxt = '0;
        if (r_remaining > 4'd1) begin
          w_remaining_nxt = r_remaining - 4'd1;
        end else begin
          // Last second elapsed; also guards against wrapping below zero.
          w_remaining_nxt = 4'd0;
          w_expired_nxt   = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end else begin
        w_div_nxt = r_div + 1'b1;
      end
    end else begin
      w_div_nxt = '0;
    end
  end

  assign o_expired   = r_expired;
  assign o_one_hz    = w_tick;
  assign o_remaining = r_remaining;
  assign o_busy      = (r_state == S_RUN);

endmodule

// File: tb/tb_alarm_timer.sv
// Directed testbench for alarm_timer with an 8-clock tick (CLK_HZ = 8).
// Cycle numbering: cycle 0 is the cycle beginning at the edge that sampled
// start_timer; outputs are sampled on the falling edge.

module tb_alarm_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_timer;
  logic [1:0] interval;
  logic       reprogram;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       expired;
  logic       one_hz;
  logic [3:0] remaining;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alarm_timer #(
    .CLK_HZ      (8),
    .T_ARM       (6),
    .T_DRIVER    (8),
    .T_PASSENGER (15),
    .T_ALARM     (10)
  ) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_start_timer    (start_timer),
    .i_interval       (interval),
    .i_reprogram      (reprogram),
    .i_time_param_sel (time_param_sel),
    .i_time_value     (time_value),
    .o_expired        (expired),
    .o_one_hz         (one_hz),
    .o_remaining      (remaining),
    .o_busy           (busy)
  );

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "timeout");
  end

  // Called at a falling edge; leaves the bench at the falling edge of cycle 0.
  task automatic do_start(input logic [1:0] iv, input logic rp,
                          input logic [1:0] sel, input logic [3:0] val);
    start_timer    = 1'b1;
    interval       = iv;
    reprogram      = rp;
    time_param_sel = sel;
    time_value     = val;
    @(posedge clk);
    @(negedge clk);
    start_timer = 1'b0;
    reprogram   = 1'b0;
  endtask

  task automatic do_reprogram(input logic [1:0] sel, input logic [3:0] val);
    reprogram      = 1'b1;
    time_param_sel = sel;
    time_value     = val;
    @(posedge clk);
    @(negedge clk);
    reprogram = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Samples n cycles starting with the current one; ends n cycles later.
  task automatic watch(input int n, output int first_exp, output int n_exp,
                       output int n_hz, output int n_busy);
    first_exp = -1;
    n_exp     = 0;
    n_hz      = 0;
    n_busy    = 0;
    for (int i = 0; i < n; i++) begin
      if (expired === 1'b1) begin
        if (first_exp < 0) first_exp = i;
        n_exp++;
      end
      if (one_hz === 1'b1) n_hz++;
      if (busy === 1'b1) n_busy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if (remaining !== 4'd0) begin n_fail++; $display("FAIL reset_remaining: got %0d expected 0", remaining); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++;
    if (expired !== 1'b0 || one_hz !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses: expired=%b one_hz=%b expected 0/0", expired, one_hz);
    end
  endtask

  task automatic test_arm();
    int fe, ne, nh, nb;
    do_start(2'b00, 1'b0, 2'b00, 4'd0);
    n_tests++;
    if (remaining !== 4'd6 || busy !== 1'b1) begin
      n_fail++; $display("FAIL arm_load: remaining=%0d busy=%b expected 6/1", remaining, busy);
    end
    watch(60, fe, ne, nh, nb);
    n_tests++;
    if (fe !== 48) begin n_fail++; $display("FAIL arm_latency: got %0d expected 48", fe); end
    n_tests++;
    if (ne !== 1) begin n_fail++; $display("FAIL arm_pulses: got %0d expected 1", ne); end
    n_tests++;
    if (nh !== 6) begin n_fail++; $display("FAIL arm_ticks: got %0d expected 6", nh); end
    n_tests++;
    if (nb !== 48) begin n_fail++; $display("FAIL arm_busy_cycles: got %0d expected 48", nb); end
    n_tests++;
    if (remaining !== 4'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL arm_end: remaining=%0d busy=%b expected 0/0", remaining, busy);
    end
  endtask

  task automatic test_reprogram();
    int fe, ne, nh, nb;
    do_reprogram(2'b01, 4'd3);
    do_start(2'b01, 1'b0, 2'b00, 4'd0);
    n_tests++;
    if (remaining !== 4'd3) begin n_fail++; $display("FAIL reprog_load: got %0d expected 3", remaining); end
    watch(30, fe, ne, nh, nb);
    n_tests++;
    if (fe !== 24 || ne !== 1) begin
      n_fail++; $display("FAIL reprog_latency: first=%0d count=%0d expected 24/1", fe, ne);
    end
    do_start(2'b10, 1'b0, 2'b00, 4'd0);
    n_tests++;
    if (remaining !== 4'd15) begin n_fail++; $display("FAIL reprog_other10: got %0d expected 15", remaining); end
    do_start(2'b00, 1'b0, 2'b00, 4'd0);
    n_tests++;
    if (remaining !== 4'd6) begin n_fail++; $display("FAIL reprog_other00: got %0d expected 6", remaining); end
    do_start(2'b11, 1'b0, 2'b00, 4'd0);
    n_tests++;
    if (remaining !== 4'd10) begin n_fail++; $display("FAIL reprog_other11: got %0d expected 10", remaining); end
    watch(85, fe, ne, nh, nb);
    n_tests++;
    if (fe !== 80 || ne !== 1 || nh !== 10) begin
      n_fail++; $display("FAIL reprog_alarm_run: first=%0d count=%0d ticks=%0d expected 80/1/10", fe, ne, nh);
    end
  endtask

  task automatic test_restart();
    int fe, ne, nh, nb;
    do_start(2'b11, 1'b0, 2'b00, 4'd0);
    watch(19, fe, ne, nh, nb);
    n_tests++;
    if (ne !== 0) begin n_fail++; $display("FAIL restart_early: got %0d pulses expected 0", ne); end
    do_start(2'b00, 1'b0, 2'b00, 4'd0);
    n_tests++;
    if (remaining !== 4'd6) begin n_fail++; $display("FAIL restart_load: got %0d expected 6", remaining); end
    // Relative cycle 60 is absolute clock 80 of the original run.
    watch(70, fe, ne, nh, nb);
    n_tests++;
    if (fe !== 48 || ne !== 1) begin
      n_fail++; $display("FAIL restart_latency: first=%0d count=%0d expected 48/1", fe, ne);
    end
  endtask

  task automatic test_align();
    int fe, ne, nh, nb;
    do_start(2'b00, 1'b0, 2'b00, 4'd0);
    watch(7, fe, ne, nh, nb);
    n_tests++;
    if (one_hz !== 1'b1 || remaining !== 4'd6) begin
      n_fail++; $display("FAIL align_tick: one_hz=%b remaining=%0d expected 1/6", one_hz, remaining);
    end
    do_start(2'b00, 1'b1, 2'b00, 4'd2);
    n_tests++;
    if (remaining !== 4'd6 || expired !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL align_start_wins: remaining=%0d expired=%b busy=%b expected 6/0/1",
                         remaining, expired, busy);
    end
    watch(50, fe, ne, nh, nb);
    n_tests++;
    if (fe !== 48 || ne !== 1) begin
      n_fail++; $display("FAIL align_latency: first=%0d count=%0d expected 48/1", fe, ne);
    end
    do_start(2'b00, 1'b0, 2'b00, 4'd0);
    n_tests++;
    if (remaining !== 4'd2) begin n_fail++; $display("FAIL align_new_value: got %0d expected 2", remaining); end
    watch(15, fe, ne, nh, nb);
    n_tests++;
    if (one_hz !== 1'b1 || remaining !== 4'd1) begin
      n_fail++; $display("FAIL align_last_tick: one_hz=%b remaining=%0d expected 1/1", one_hz, remaining);
    end
    do_start(2'b00, 1'b0, 2'b00, 4'd0);
    n_tests++;
    if (remaining !== 4'd2 || expired !== 1'b0) begin
      n_fail++; $display("FAIL align_no_expire: remaining=%0d expired=%b expected 2/0", remaining, expired);
    end
    watch(20, fe, ne, nh, nb);
    n_tests++;
    if (fe !== 16 || ne !== 1) begin
      n_fail++; $display("FAIL align_relatency: first=%0d count=%0d expected 16/1", fe, ne);
    end
  endtask

  task automatic test_zero_load();
    int fe, ne, nh, nb;
    do_reprogram(2'b11, 4'd0);
    do_start(2'b11, 1'b0, 2'b00, 4'd0);
    n_tests++;
    if (expired !== 1'b1 || busy !== 1'b0 || remaining !== 4'd0) begin
      n_fail++; $display("FAIL zero_immediate: expired=%b busy=%b remaining=%0d expected 1/0/0",
                         expired, busy, remaining);
    end
    watch(20, fe, ne, nh, nb);
    n_tests++;
    if (fe !== 0 || ne !== 1 || nh !== 0 || nb !== 0) begin
      n_fail++; $display("FAIL zero_quiet: first=%0d count=%0d ticks=%0d busy=%0d expected 0/1/0/0",
                         fe, ne, nh, nb);
    end
  endtask

  task automatic test_reset_abort();
    int fe, ne, nh, nb;
    do_start(2'b10, 1'b0, 2'b00, 4'd0);
    watch(49, fe, ne, nh, nb);
    do_reset();
    n_tests++;
    if (remaining !== 4'd0 || busy !== 1'b0 || expired !== 1'b0) begin
      n_fail++; $display("FAIL abort_state: remaining=%0d busy=%b expired=%b expected 0/0/0",
                         remaining, busy, expired);
    end
    watch(150, fe, ne, nh, nb);
    n_tests++;
    if (ne !== 0 || nh !== 0 || nb !== 0) begin
      n_fail++; $display("FAIL abort_quiet: pulses=%0d ticks=%0d busy=%0d expected 0/0/0", ne, nh, nb);
    end
    do_start(2'b00, 1'b0, 2'b00, 4'd0);
    n_tests++;
    if (remaining !== 4'd6) begin n_fail++; $display("FAIL abort_reg00: got %0d expected 6", remaining); end
    do_start(2'b01, 1'b0, 2'b00, 4'd0);
    n_tests++;
    if (remaining !== 4'd8) begin n_fail++; $display("FAIL abort_reg01: got %0d expected 8", remaining); end
    do_start(2'b10, 1'b0, 2'b00, 4'd0);
    n_tests++;
    if (remaining !== 4'd15) begin n_fail++; $display("FAIL abort_reg10: got %0d expected 15", remaining); end
    do_start(2'b11, 1'b0, 2'b00, 4'd0);
    n_tests++;
    if (remaining !== 4'd10) begin n_fail++; $display("FAIL abort_reg11: got %0d expected 10", remaining); end
    do_reset();
  endtask

  initial begin
    reset          = 1'b1;
    start_timer    = 1'b0;
    interval       = 2'b00;
    reprogram      = 1'b0;
    time_param_sel = 2'b00;
    time_value     = 4'd0;
    test_reset();
    test_arm();
    test_reprogram();
    test_restart();
    test_align();
    test_zero_load();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_timer.md
ALARM_TIMER -- requirements
Module: alarm_timer

Interface
REQ-001 Parameter: CLK_HZ, default 27000000, clock cycles per one-second tick (N).
REQ-002 Parameter: T_ARM, default 6; T_DRIVER, default 8; T_PASSENGER, default 15; T_ALARM, default 10; reset-time seconds for the four intervals.
REQ-003 clk  input  1  system clock; single clock domain; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start_timer  input  1  one-cycle request from the alarm FSM to load and start the countdown.
REQ-006 interval  input  2  interval select: 00 arm delay, 01 driver delay, 10 passenger delay, 11 alarm-on.
REQ-007 reprogram  input  1  one-cycle strobe: write time_value into the register chosen by time_param_sel.
REQ-008 time_param_sel  input  2  register to reprogram, same encoding as interval.
REQ-009 time_value  input  4  new duration in seconds, 0-15.
REQ-010 expired  output  1  one-cycle pulse when the countdown reaches zero.
REQ-011 one_hz  output  1  one-cycle tick pulse, asserted only while the block is in RUN.
REQ-012 remaining  output  4  current countdown value in seconds.
REQ-013 busy  output  1  high while the block is in RUN.

Function
REQ-014 Four 4-bit duration registers shall hold the values for intervals 00-11.
REQ-015 A reprogram strobe shall write time_value into the register chosen by time_param_sel at that edge; the other three registers are unchanged.
REQ-016 States: IDLE and RUN; busy = (state == RUN).
REQ-017 Start: start_timer in either state shall load remaining from the register chosen by interval, clear the divider to 0, and enter RUN; a start during RUN restarts the countdown.
REQ-018 Divider: in RUN it shall count 0..N-1 and wrap; one_hz is asserted when divider == N-1 and state == RUN.
REQ-019 Decrement: on each one_hz edge, remaining shall decrement by 1.
REQ-020 If remaining == 1 at a one_hz edge, remaining shall become 0, expired shall be registered high for exactly one cycle, and state shall return to IDLE.
REQ-021 Latency: for a loaded value V >= 1, expired shall be high in the single cycle beginning V*N clocks after the edge that sampled start_timer.
REQ-022 Zero load: if the loaded value is 0, expired shall pulse in the cycle after the start edge, state shall stay IDLE, and no one_hz tick shall be issued.
REQ-023 Start and one_hz in the same cycle: start wins; no decrement and no expired pulse occur.
REQ-024 Reprogram and start in the same cycle: start loads the value held before that edge, and the register updates.
REQ-025 Reprogramming during RUN shall not alter the countdown in progress.
REQ-026 In IDLE, the divider shall hold at 0 and remaining shall hold its value.
REQ-027 remaining shall never wrap below 0.

Reset
REQ-028 On reset at a clock edge, the block shall enter IDLE with divider 0, remaining 0, expired 0, and one_hz 0.
REQ-029 On reset, the duration registers shall take T_ARM, T_DRIVER, T_PASSENGER and T_ALARM.
REQ-030 Reset shall take priority over start_timer and reprogram; a reset in RUN shall abort the countdown with no expired pulse.

Configuration
REQ-031 Macro ALARM_TIMER_FASTSIM_EN, when defined, shall replace the divider period N with 8 clocks regardless of CLK_HZ.
REQ-032 Without ALARM_TIMER_FASTSIM_EN, N = CLK_HZ; all other behaviour is identical in both builds.

Verification (ALARM_TIMER_FASTSIM_EN defined, N = 8)
REQ-033 Reset, then start_timer with interval=00 -> remaining=6 and busy=1; expired pulses for one cycle at 48 clocks; exactly six one_hz pulses are issued.
REQ-034 reprogram with sel=01 and value=3, then start with interval=01 -> expired at 24 clocks; a follow-up start with interval=10 loads 15, confirming the other registers are untouched.
REQ-035 Start with interval=11; at clock 20 start again with interval=00 -> expired at 20+48 clocks only, with no pulse at 80.
REQ-036 reprogram with sel=11 and value=0, then start with interval=11 -> expired the next cycle, busy stays 0, no one_hz pulse.
REQ-037 Start with interval=10; assert reset at clock 50 -> no expired pulse, remaining=0, all registers restored to 6/8/15/10.
REQ-038 Start aligned with a one_hz cycle, plus simultaneous reprogram and start on the same register -> start wins, old value loaded, new value seen on the next start.
